uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Serial receiver paired with uart_tx; consumes the serial line uart_tx drives.
//  Uses the same runtime configuration inputs: baud_rate, parity_type, stop_bits
//  and data_length.
//  Oversamples the line 16x, recovers one frame and presents it in parallel.
//  Flags parity and framing errors and pulses rx_done once per frame.
// PARAMETERS
//  CLK_FREQ   50000000  system clock frequency in Hz; sets the 16x tick divisors
//  SYNC_STAGES 2        depth of the rx_in metastability synchroniser (>=2)
// PORTS
//  clock        in   1  system clock
//  rst          in   1  reset; asynchronous, active-high
//  rx_in        in   1  serial input; idles high; asynchronous to clock
//  baud_rate    in   2  baud select: 00=2400, 01=4800, 10=9600, 11=19200
//  parity_type  in   2  00=none, 01=odd, 10=even, 11=none
//  stop_bits    in   1  0=one stop bit, 1=two stop bits
//  data_length  in   1  0=7 data bits, 1=8 data bits
//  data_out     out  8  received data, LSB first on the wire; bit7=0 in 7-bit mode
//  rx_done      out  1  one-clock pulse when data_out and the error flags are valid
//  rx_active    out  1  high from the confirmed start bit until rx_done
//  parity_error out  1  parity mismatch in the last frame; valid with rx_done
//  frame_error  out  1  a stop bit was sampled low in the last frame; valid with rx_done
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0.
//    rst asserted mid-frame aborts the frame immediately and gives no rx_done.
//  - tick16: one-clock pulse every DIV clocks. DIV = round(CLK_FREQ/(16*baud)):
//    1302, 651, 326, 163. The divider restarts on any baud_rate change.
//  - Config: baud_rate, parity_type, stop_bits and data_length are latched when the
//    start bit is confirmed. Changes during a frame take effect at the next frame.
//  - FSM is IDLE -> START -> DATA -> PARITY -> STOP -> DONE -> IDLE.
//  - IDLE: a synchronised falling edge (1->0) moves to START and clears the tick
//    counter.
//  - START: at tick count 7 (mid-bit), re-sample the line.
//    Low: confirm the start bit, set rx_active and restart the counter.
//    High: treat as a glitch, return to IDLE, set no flags.
//  - DATA: sample every 16 ticks at mid-bit and shift in LSB first.
//    Take 7 or 8 samples per the latched data_length.
//  - PARITY: entered only when parity_type is 01 or 10; one sample.
//    parity_error = (^data ^ sampled bit) != expected.
//    Expected result: 1 for odd, 0 for even.
//    With no parity, skip this state and hold parity_error at 0.
//  - STOP: take one or two mid-bit samples.
//    frame_error = 1 if any stop sample is 0.
//    After a low stop bit, wait for the line to go high before accepting a new
//    start, so a break condition produces exactly one frame.
//  - DONE: one clock. Update data_out, parity_error and frame_error.
//    Pulse rx_done and deassert rx_active in the same cycle, then go to IDLE.
//  - Latency: rx_done rises 1 clock after the mid-point sample of the last stop bit,
//    plus SYNC_STAGES of input delay.
//  - Back-to-back frames: a start edge arriving one tick after the last stop sample
//    must be caught.
//  - data_out and the error flags hold their values until the next DONE.
//  - Bit counter is 3 bits wide; tick counter is 4 bits wide and wraps 15 -> 0.
// STRUCTURE
//  - Package uart_pkg holds:
//    - baud divisor constants and the function DIV(CLK_FREQ, sel);
//    - parity_type encodings PAR_NONE, PAR_ODD, PAR_EVEN;
//    - the rx state enum.
//    uart_tx's baud generator also uses this package.
//  - Sub-module uart_rx_baud16: generates tick16 from clock, rst and baud_rate.
//  - The FSM, shifter and synchroniser stay in uart_rx.
// TESTING
//  1. 9600 8N1, send 0xA5 -> data_out=A5, parity_error=0, frame_error=0, one rx_done.
//  2. 19200 7-bit odd parity, send 0x35 with parity bit 1 -> data_out=35, parity_error=0.
//     Same frame with parity bit 0 -> parity_error=1.
//  3. 2400 8E2, second stop bit driven 0 -> frame_error=1.
//     Line held low for 3 frames -> exactly one rx_done, data_out=00.
//  4. 4800, a 0.25-bit low glitch on idle -> no rx_active, no rx_done.
//  5. rst pulsed mid-DATA of 0x5A, then a clean 0xC3 -> only C3 is reported.
//     All outputs are 0 during reset.
//  6. Loopback uart_tx -> uart_rx at every baud_rate/parity_type/stop_bits/data_length
//    combination, 256 bytes each -> all bytes match, no error flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors, parity encodings and receiver states.
package uart_pkg;

    localparam int unsigned BAUD_2400  = 2400;
    localparam int unsigned BAUD_4800  = 4800;
    localparam int unsigned BAUD_9600  = 9600;
    localparam int unsigned BAUD_19200 = 19200;

    localparam int unsigned TICK_W = 4;
    localparam int unsigned BIT_W  = 3;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_DONE
    } rx_state_e;

    // Baud rate in Hz for a baud_rate select code.
    function automatic int unsigned baud_hz(input logic [1:0] sel);
        int unsigned hz;
        case (sel)
            2'b00:   hz = BAUD_2400;
            2'b01:   hz = BAUD_4800;
            2'b10:   hz = BAUD_9600;
            default: hz = BAUD_19200;
        endcase
        return hz;
    endfunction

    // 16x tick divisor, rounded to nearest: round(clk_freq / (16 * baud)).
    function automatic int unsigned DIV(input int unsigned clk_freq, input logic [1:0] sel);
        int unsigned hz;
        hz = baud_hz(sel);
        return (clk_freq + 32'd8 * hz) / (32'd16 * hz);
    endfunction

    localparam int unsigned DIV_50M_2400  = DIV(32'd50000000, 2'b00);
    localparam int unsigned DIV_50M_4800  = DIV(32'd50000000, 2'b01);
    localparam int unsigned DIV_50M_9600  = DIV(32'd50000000, 2'b10);
    localparam int unsigned DIV_50M_19200 = DIV(32'd50000000, 2'b11);

endpackage

// File: rtl/uart_rx_baud16.sv
// 16x oversampling tick generator; restarts whenever the baud select changes.
module uart_rx_baud16
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] baud_rate_i,
    output logic       tick16_o
);

    localparam int unsigned DIV_0 = DIV(CLK_FREQ, 2'b00);
    localparam int unsigned DIV_1 = DIV(CLK_FREQ, 2'b01);
    localparam int unsigned DIV_2 = DIV(CLK_FREQ, 2'b10);
    localparam int unsigned DIV_3 = DIV(CLK_FREQ, 2'b11);
    localparam int unsigned CNT_W = (DIV_0 > 1) ? $clog2(DIV_0) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d, limit_c;
    logic [1:0]       baud_q;
    logic             tick_q, tick_d;

    // Terminal count for the selected baud rate.
    always_comb begin
        case (baud_rate_i)
            2'b00:   limit_c = CNT_W'(DIV_0 - 1);
            2'b01:   limit_c = CNT_W'(DIV_1 - 1);
            2'b10:   limit_c = CNT_W'(DIV_2 - 1);
            default: limit_c = CNT_W'(DIV_3 - 1);
        endcase
    end

    // Count to the terminal value, emit one tick and wrap; a baud change restarts.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (baud_rate_i != baud_q) begin
            cnt_d = '0;
        end else if (cnt_q >= limit_c) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Divider state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            baud_q <= 2'b00;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            baud_q <= baud_rate_i;
            tick_q <= tick_d;
        end
    end

    assign tick16_o = tick_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, runtime-configurable frame, parity/framing checks.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       rx_active,
    output logic       parity_error,
    output logic       frame_error
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic                   rx_s_c, fall_c;

    rx_state_e          state_q, state_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [1:0]         baud_q, baud_d;
    logic [1:0]         par_q, par_d;
    logic               stop_q, stop_d;
    logic               len_q, len_d;
    logic               fe_acc_q, fe_acc_d;
    logic               pe_pend_q, pe_pend_d;
    logic [7:0]         data_out_q, data_out_d;
    logic               rx_done_q, rx_done_d;
    logic               rx_active_q, rx_active_d;
    logic               parity_error_q, parity_error_d;
    logic               frame_error_q, frame_error_d;

    logic               tick16_c, mid_c, par_en_c, stop_last_c;
    logic [1:0]         baud_sel_c;
    logic [BIT_W-1:0]   last_bit_c;
    logic [7:0]         data_c;

    // Metastability synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_in};
            rx_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_s_c = sync_q[SYNC_STAGES-1];
    assign fall_c = rx_prev_q & ~rx_s_c;

    // Live baud select while hunting for a start bit, latched one during the frame.
    assign baud_sel_c = (state_q == RX_IDLE || state_q == RX_START) ? baud_rate : baud_q;

    uart_rx_baud16 #(
        .CLK_FREQ (CLK_FREQ)
    ) u_baud16 (
        .clk_i       (clock),
        .rst_i       (rst),
        .baud_rate_i (baud_sel_c),
        .tick16_o    (tick16_c)
    );

    assign mid_c       = tick16_c && (tick_cnt_q == TICK_W'(15));
    assign par_en_c    = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
    assign last_bit_c  = len_q ? BIT_W'(7) : BIT_W'(6);
    assign stop_last_c = (bit_cnt_q == BIT_W'(stop_q));
    // In 7-bit mode the shifter holds the data in [7:1].
    assign data_c      = len_q ? shift_q : {1'b0, shift_q[7:1]};

    // Next-state, datapath and output logic.
    always_comb begin
        state_d        = state_q;
        tick_cnt_d     = tick_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        baud_d         = baud_q;
        par_d          = par_q;
        stop_d         = stop_q;
        len_d          = len_q;
        fe_acc_d       = fe_acc_q;
        pe_pend_d      = pe_pend_q;
        data_out_d     = data_out_q;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;
        rx_done_d      = 1'b0;
        rx_active_d    = rx_active_q;

        if (tick16_c && state_q != RX_IDLE && state_q != RX_DONE) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end

        case (state_q)
            RX_IDLE: begin
                if (fall_c) begin
                    state_d    = RX_START;
                    tick_cnt_d = '0;
                end
            end
            RX_START: begin
                if (tick16_c && tick_cnt_q == TICK_W'(7)) begin
                    if (!rx_s_c) begin
                        state_d     = RX_DATA;
                        tick_cnt_d  = '0;
                        bit_cnt_d   = '0;
                        shift_d     = '0;
                        baud_d      = baud_rate;
                        par_d       = parity_type;
                        stop_d      = stop_bits;
                        len_d       = data_length;
                        fe_acc_d    = 1'b0;
                        pe_pend_d   = 1'b0;
                        rx_active_d = 1'b1;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (mid_c) begin
                    shift_d   = {rx_s_c, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == last_bit_c) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_c ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (mid_c) begin
                    pe_pend_d = ((^data_c) ^ rx_s_c) != (par_q == PAR_ODD);
                    state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (mid_c) begin
                    if (stop_last_c) begin
                        state_d        = RX_DONE;
                        rx_done_d      = 1'b1;
                        rx_active_d    = 1'b0;
                        data_out_d     = data_c;
                        parity_error_d = pe_pend_q;
                        frame_error_d  = fe_acc_q | ~rx_s_c;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        fe_acc_d  = fe_acc_q | ~rx_s_c;
                    end
                end
            end
            RX_DONE: begin
                // A start edge landing in this cycle must not be lost.
                state_d = RX_IDLE;
                if (fall_c) begin
                    state_d    = RX_START;
                    tick_cnt_d = '0;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q        <= RX_IDLE;
            tick_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            baud_q         <= 2'b00;
            par_q          <= PAR_NONE;
            stop_q         <= 1'b0;
            len_q          <= 1'b0;
            fe_acc_q       <= 1'b0;
            pe_pend_q      <= 1'b0;
            data_out_q     <= '0;
            rx_done_q      <= 1'b0;
            rx_active_q    <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            baud_q         <= baud_d;
            par_q          <= par_d;
            stop_q         <= stop_d;
            len_q          <= len_d;
            fe_acc_q       <= fe_acc_d;
            pe_pend_q      <= pe_pend_d;
            data_out_q     <= data_out_d;
            rx_done_q      <= rx_done_d;
            rx_active_q    <= rx_active_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign data_out     = data_out_q;
    assign rx_done      = rx_done_q;
    assign rx_active    = rx_active_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serial transmitter drives frames
// and a frame-level model predicts data and error flags.
module tb_uart_rx;
    import uart_pkg::*;

    // Low clock frequency keeps bit times short: divisors 8, 4, 2, 1.
    localparam int unsigned CLK_FREQ = 307200;

    logic       clock;
    logic       rst;
    logic       rx_in;
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       data_length;
    logic [7:0] data_out;
    logic       rx_done;
    logic       rx_active;
    logic       parity_error;
    logic       frame_error;

    int n_checks = 0;
    int n_fail   = 0;

    int         done_cnt    = 0;
    int         active_cnt  = 0;
    int         overlap_cnt = 0;
    logic [7:0] got_data [64];

    uart_rx #(
        .CLK_FREQ    (CLK_FREQ),
        .SYNC_STAGES (2)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .rx_in        (rx_in),
        .baud_rate    (baud_rate),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .data_length  (data_length),
        .data_out     (data_out),
        .rx_done      (rx_done),
        .rx_active    (rx_active),
        .parity_error (parity_error),
        .frame_error  (frame_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every reported frame and activity, sampled away from the active edge.
    always @(negedge clock) begin
        if (rx_done === 1'b1) begin
            got_data[done_cnt % 64] = data_out;
            done_cnt = done_cnt + 1;
        end
        if (rx_active === 1'b1) active_cnt = active_cnt + 1;
        if (rx_done === 1'b1 && rx_active === 1'b1) overlap_cnt = overlap_cnt + 1;
    end

    // Clocks per 16x tick, from round(CLK_FREQ / (16 * baud)).
    function automatic int unsigned tb_div(input logic [1:0] sel);
        real hz;
        hz = 2400.0 * real'(1 << sel);
        return int'($rtoi(real'(CLK_FREQ) / (16.0 * hz) + 0.5));
    endfunction

    task automatic drive(input logic v, input int unsigned clks);
        rx_in = v;
        repeat (clks) @(negedge clock);
    endtask

    task automatic set_cfg(input logic [1:0] b, input logic [1:0] p, input logic s, input logic l);
        baud_rate   = b;
        parity_type = p;
        stop_bits   = s;
        data_length = l;
        repeat (2) @(negedge clock);
    endtask

    // Transmit one frame with the current config and predict the receiver's report.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop2_low,
                              input int unsigned last_ticks,
                              output logic [7:0] ed, output logic epe, output logic efe);
        int unsigned t;
        int          nb;
        int          ones;
        bit          odd;
        bit          par_en;
        logic        pbit;
        t      = tb_div(baud_rate);
        nb     = data_length ? 8 : 7;
        ed     = data_length ? d : {1'b0, d[6:0]};
        ones   = $countones(ed);
        odd    = (parity_type == 2'b01);
        par_en = odd || (parity_type == 2'b10);
        pbit   = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        if (bad_par) pbit = ~pbit;
        epe = par_en && (((ones + int'(pbit)) % 2) != (odd ? 1 : 0));
        efe = stop_bits && stop2_low;
        drive(1'b0, 16 * t);
        for (int i = 0; i < nb; i++) drive(ed[i], 16 * t);
        if (par_en) drive(pbit, 16 * t);
        if (stop_bits) begin
            drive(1'b1, 16 * t);
            drive(!stop2_low, last_ticks * t);
        end else begin
            drive(1'b1, last_ticks * t);
        end
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_in = 1'b1;
        baud_rate = 2'b00; parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({data_out, rx_done, rx_active, parity_error, frame_error} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 000",
                     {data_out, rx_done, rx_active, parity_error, frame_error});
        end
        rst = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic test_div();
        int unsigned exp_div [4];
        int unsigned got;
        exp_div = '{1302, 651, 326, 163};
        for (int s = 0; s < 4; s++) begin
            got = DIV(32'd50000000, 2'(s));
            n_checks++;
            if (got !== exp_div[s]) begin
                n_fail++;
                $display("FAIL div_50m sel=%0d: got %0d expected %0d", s, got, exp_div[s]);
            end
        end
    endtask

    task automatic test_8n1();
        logic [7:0] ed;
        logic       epe, efe;
        int         n0, a0;
        set_cfg(2'b10, 2'b00, 1'b0, 1'b1);
        n0 = done_cnt;
        a0 = active_cnt;
        drive(1'b1, $urandom_range(1, 15));
        send_frame(8'hA5, 1'b0, 1'b0, 16, ed, epe, efe);
        drive(1'b1, 4 * tb_div(baud_rate));
        n_checks++;
        if (done_cnt - n0 !== 1) begin
            n_fail++;
            $display("FAIL 8n1_done_count: got %0d expected 1", done_cnt - n0);
        end
        n_checks++;
        if ({data_out, parity_error, frame_error} !== {ed, epe, efe}) begin
            n_fail++;
            $display("FAIL 8n1_frame: got %h/%b/%b expected %h/%b/%b",
                     data_out, parity_error, frame_error, ed, epe, efe);
        end
        n_checks++;
        if (!(active_cnt > a0)) begin
            n_fail++;
            $display("FAIL 8n1_active: got %0d active cycles expected >0", active_cnt - a0);
        end
    endtask

    task automatic test_parity();
        logic [7:0] ed;
        logic       epe, efe;
        int         n0;
        set_cfg(2'b11, 2'b01, 1'b0, 1'b0);
        for (int bad = 0; bad < 2; bad++) begin
            n0 = done_cnt;
            drive(1'b1, $urandom_range(1, 15));
            send_frame(8'h35, bad[0], 1'b0, 16, ed, epe, efe);
            drive(1'b1, 4 * tb_div(baud_rate));
            n_checks++;
            if (done_cnt - n0 !== 1) begin
                n_fail++;
                $display("FAIL parity_done_count bad=%0d: got %0d expected 1", bad, done_cnt - n0);
            end
            n_checks++;
            if ({data_out, parity_error, frame_error} !== {ed, epe, efe}) begin
                n_fail++;
                $display("FAIL parity_frame bad=%0d: got %h/%b/%b expected %h/%b/%b", bad,
                         data_out, parity_error, frame_error, ed, epe, efe);
            end
        end
    endtask

    task automatic test_break();
        logic [7:0] ed;
        logic       epe, efe;
        int         n0;
        int unsigned t;
        set_cfg(2'b00, 2'b10, 1'b1, 1'b1);
        t  = tb_div(baud_rate);
        n0 = done_cnt;
        drive(1'b1, $urandom_range(1, 15));
        send_frame(8'($urandom), 1'b0, 1'b1, 16, ed, epe, efe);
        drive(1'b1, 16 * t);
        n_checks++;
        if (done_cnt - n0 !== 1 || {data_out, parity_error, frame_error} !== {ed, epe, efe}) begin
            n_fail++;
            $display("FAIL stop2_low: got n=%0d %h/%b/%b expected n=1 %h/%b/%b", done_cnt - n0,
                     data_out, parity_error, frame_error, ed, epe, efe);
        end
        // Line held low for three 12-bit frames: one all-zero frame, even parity ok.
        n0 = done_cnt;
        drive(1'b0, 3 * 12 * 16 * t);
        drive(1'b1, 32 * t);
        n_checks++;
        if (done_cnt - n0 !== 1) begin
            n_fail++;
            $display("FAIL break_done_count: got %0d expected 1", done_cnt - n0);
        end
        n_checks++;
        if ({data_out, parity_error, frame_error} !== {8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL break_frame: got %h/%b/%b expected 00/0/1",
                     data_out, parity_error, frame_error);
        end
    endtask

    task automatic test_glitch();
        int n0, a0;
        int unsigned t;
        set_cfg(2'b01, 2'b00, 1'b0, 1'b1);
        t  = tb_div(baud_rate);
        n0 = done_cnt;
        a0 = active_cnt;
        drive(1'b1, $urandom_range(1, 15));
        drive(1'b0, 4 * t);
        drive(1'b1, 32 * t);
        n_checks++;
        if (done_cnt - n0 !== 0 || active_cnt - a0 !== 0) begin
            n_fail++;
            $display("FAIL glitch: got done=%0d active=%0d expected 0/0",
                     done_cnt - n0, active_cnt - a0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        logic [7:0] ed;
        logic       epe, efe;
        int         n0;
        int unsigned t;
        set_cfg(2'b10, 2'b00, 1'b0, 1'b1);
        t  = tb_div(baud_rate);
        n0 = done_cnt;
        d  = 8'h5A;
        drive(1'b1, $urandom_range(1, 15));
        drive(1'b0, 16 * t);
        for (int i = 0; i < 4; i++) drive(d[i], 16 * t);
        n_checks++;
        if (rx_active !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_active: got %b expected 1", rx_active);
        end
        rst   = 1'b1;
        rx_in = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({data_out, rx_done, rx_active, parity_error, frame_error} !== 12'h000) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got %h expected 000",
                     {data_out, rx_done, rx_active, parity_error, frame_error});
        end
        repeat (3) @(negedge clock);
        rst = 1'b0;
        drive(1'b1, 32 * t);
        send_frame(8'hC3, 1'b0, 1'b0, 16, ed, epe, efe);
        drive(1'b1, 4 * t);
        n_checks++;
        if (done_cnt - n0 !== 1 || {data_out, parity_error, frame_error} !== {ed, epe, efe}) begin
            n_fail++;
            $display("FAIL midframe_recovery: got n=%0d %h/%b/%b expected n=1 %h/%b/%b",
                     done_cnt - n0, data_out, parity_error, frame_error, ed, epe, efe);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [6];
        logic [7:0] ed;
        logic       epe, efe;
        int         n0;
        set_cfg(2'b10, 2'b00, 1'b0, 1'b1);
        n0 = done_cnt;
        drive(1'b1, $urandom_range(1, 15));
        // Stop bit cut to 10 ticks: the next start edge follows the stop sample closely.
        for (int i = 0; i < 6; i++) begin
            send_frame(8'($urandom), 1'b0, 1'b0, (i == 5) ? 16 : 10, ed, epe, efe);
            exp_d[i] = ed;
        end
        drive(1'b1, 4 * tb_div(baud_rate));
        n_checks++;
        if (done_cnt - n0 !== 6) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d expected 6", done_cnt - n0);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got_data[(n0 + i) % 64] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_data[(n0 + i) % 64], exp_d[i]);
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] ed;
        logic       epe, efe;
        int         n0;
        for (int b = 0; b < 4; b++)
        for (int p = 0; p < 4; p++)
        for (int s = 0; s < 2; s++)
        for (int l = 0; l < 2; l++) begin
            set_cfg(2'(b), 2'(p), 1'(s), 1'(l));
            for (int r = 0; r < ((b == 3) ? 2 : 1); r++) begin
                n0 = done_cnt;
                drive(1'b1, $urandom_range(1, 20));
                send_frame(8'($urandom), 1'b0, 1'b0, 16, ed, epe, efe);
                drive(1'b1, 2 * tb_div(baud_rate));
                n_checks++;
                if (done_cnt - n0 !== 1 || {data_out, parity_error, frame_error} !== {ed, epe, efe}) begin
                    n_fail++;
                    $display("FAIL loopback b=%0d p=%0d s=%0d l=%0d: got n=%0d %h/%b/%b expected n=1 %h/%b/%b",
                             b, p, s, l, done_cnt - n0, data_out, parity_error, frame_error, ed, epe, efe);
                end
            end
        end
    endtask

    task automatic test_done_active_exclusive();
        n_checks++;
        if (overlap_cnt !== 0) begin
            n_fail++;
            $display("FAIL done_active_overlap: got %0d cycles expected 0", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_div();
        test_8n1();
        test_parity();
        test_break();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        test_loopback();
        test_done_active_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
